// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Purpose  : Byte-command sequencer that loads a program into instruction
//            memory from a serial byte stream, then runs or single-steps the
//            CPU until the decoder reports halt.
// Ports    : i_clk, i_reset       clock, async active-high reset
//            i_RxData, i_RxValid  received command/data byte + strobe
//            i_Halt               CPU halt flag from the decoder
//            o_ProgWe/Addr/Data   program memory write port
//            o_CpuEn, o_CpuRst    CPU advance enable / CPU sync reset
//            o_State              current state code
//            o_Cycles             executed-cycle count (saturating)
//            o_Done, o_Error      program finished / one-cycle error pulse
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
  parameter int NBITS_0     = 11,
  parameter int NBITS_D     = 16,
  parameter int OPCODE      = 5,
  parameter int HALT_OPCODE = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_RxData,
  input  logic               i_RxValid,
  input  logic               i_Halt,
  output logic               o_ProgWe,
  output logic [NBITS_0-1:0] o_ProgAddr,
  output logic [NBITS_D-1:0] o_ProgData,
  output logic               o_CpuEn,
  output logic               o_CpuRst,
  output logic [2:0]         o_State,
  output logic [15:0]        o_Cycles,
  output logic               o_Done,
  output logic               o_Error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_LO = 3'd1,
    S_LOAD_HI = 3'd2,
    S_WRITE   = 3'd3,
    S_STEP    = 3'd4,
    S_RUN     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [7:0]        CMD_LOAD = 8'h4C;
  localparam logic [7:0]        CMD_RUN  = 8'h52;
  localparam logic [7:0]        CMD_STEP = 8'h53;
  localparam logic [OPCODE-1:0] HALT_OP  = HALT_OPCODE[OPCODE-1:0];

  state_t               state_q, state_d;
  logic [NBITS_0-1:0]   wr_cnt_q, wr_cnt_d;
  logic                 loaded_q, loaded_d;
  logic [NBITS_D-1:0]   data_q, data_d;
  logic [15:0]          cycles_q, cycles_d;
  logic                 error_q, error_d;

  logic                 cpu_en;
  logic                 cpu_rst;
  logic                 prog_we;
  logic                 done;
  logic                 cycles_clr;
  logic                 op_is_halt;
  logic                 addr_last;

  assign op_is_halt = (data_q[NBITS_D-1 -: OPCODE] == HALT_OP);
  assign addr_last  = &wr_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      loaded_q <= 1'b0;
      data_q   <= '0;
      cycles_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      loaded_q <= loaded_d;
      data_q   <= data_d;
      cycles_q <= cycles_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    loaded_d   = loaded_q;
    data_d     = data_q;
    error_d    = 1'b0;
    cpu_en     = 1'b0;
    cpu_rst    = 1'b0;
    prog_we    = 1'b0;
    done       = 1'b0;
    cycles_clr = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cpu_rst = 1'b1;
        if (i_RxValid) begin
          if (i_RxData == CMD_LOAD) begin
            state_d  = S_LOAD_LO;
            wr_cnt_d = '0;
            loaded_d = 1'b0;
          end else if ((i_RxData == CMD_RUN || i_RxData == CMD_STEP) && loaded_q) begin
            state_d    = (i_RxData == CMD_RUN) ? S_RUN : S_STEP;
            cycles_clr = 1'b1;
          end else begin
            // Unknown byte, or run/step with no complete program loaded.
            error_d = 1'b1;
          end
        end
      end
      S_LOAD_LO: begin
        cpu_rst = 1'b1;
        if (i_RxValid) begin
          data_d[7:0] = i_RxData;
          state_d     = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        cpu_rst = 1'b1;
        if (i_RxValid) begin
          data_d[15:8] = i_RxData;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        cpu_rst  = 1'b1;
        prog_we  = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;   // wraps to 0 after the last address
        // The write slot cannot accept a byte; drop it and flag it.
        if (i_RxValid) error_d = 1'b1;
        if (op_is_halt) begin
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end else if (addr_last) begin
          // Memory full without a halt word: keep what was loaded, flag it.
          loaded_d = 1'b1;
          error_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_LOAD_LO;
        end
      end
      S_STEP: begin
        // Halt wins over any byte in the same cycle, suppressing the pulse.
        if (i_Halt) begin
          state_d = S_DONE;
        end else if (i_RxValid) begin
          if (i_RxData == CMD_STEP)     cpu_en  = 1'b1;
          else if (i_RxData == CMD_RUN) state_d = S_RUN;
          else                          error_d = 1'b1;
        end
      end
      S_RUN: begin
        cpu_en = ~i_Halt;
        if (i_Halt) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (i_RxValid) state_d = S_IDLE;
      end
      default: begin
        cpu_rst = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (cycles_clr)                     cycles_d = '0;
    else if (cpu_en && !(&cycles_q))    cycles_d = cycles_q + 16'd1;
    else                                cycles_d = cycles_q;
  end

  assign o_ProgWe   = prog_we;
  assign o_ProgAddr = wr_cnt_q;
  assign o_ProgData = data_q;
  assign o_CpuEn    = cpu_en;
  assign o_CpuRst   = cpu_rst;
  assign o_State    = state_q;
  assign o_Cycles   = cycles_q;
  assign o_Done     = done;
  assign o_Error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_sequencer
// Purpose  : Directed self-checking bench for exec_sequencer. A behavioural
//            model predicts every output each cycle; literal checks pin the
//            key scenarios (load, run, step, errors, wrap, mid-op reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int OPC_W = 5;
  localparam int HALT  = 0;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [7:0]    i_RxData = 8'h00;
  logic          i_RxValid = 1'b0;
  logic          i_Halt = 1'b0;
  logic          o_ProgWe;
  logic [AW-1:0] o_ProgAddr;
  logic [DW-1:0] o_ProgData;
  logic          o_CpuEn;
  logic          o_CpuRst;
  logic [2:0]    o_State;
  logic [15:0]   o_Cycles;
  logic          o_Done;
  logic          o_Error;

  exec_sequencer #(
    .NBITS_0(AW), .NBITS_D(DW), .OPCODE(OPC_W), .HALT_OPCODE(HALT)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_RxData(i_RxData), .i_RxValid(i_RxValid),
    .i_Halt(i_Halt), .o_ProgWe(o_ProgWe), .o_ProgAddr(o_ProgAddr),
    .o_ProgData(o_ProgData), .o_CpuEn(o_CpuEn), .o_CpuRst(o_CpuRst),
    .o_State(o_State), .o_Cycles(o_Cycles), .o_Done(o_Done), .o_Error(o_Error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: mode number, write pointer, loaded flag, latched word
  // bytes, cycle count and the error expected to be visible this cycle.
  int m_mode, m_cnt, m_lo, m_hi, m_cycles;
  bit m_loaded, m_err;

  int en_pulses;
  int wq_addr[$];
  int wq_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_cycles = 0;
    m_loaded = 0; m_err = 0;
  endtask

  // Compare all outputs against the model for the current inputs, then
  // advance the model to what the coming clock edge must produce.
  task automatic cyc(input bit v, input logic [7:0] d, input bit h);
    bit exp_en, err_n;
    @(negedge clk);
    i_RxValid = v; i_RxData = d; i_Halt = h;
    #1;
    exp_en = (m_mode == 5 && !h) || (m_mode == 4 && !h && v && d == 8'h53);
    chk("state",    o_State,    m_mode);
    chk("cpu_en",   o_CpuEn,    exp_en);
    chk("cpu_rst",  o_CpuRst,   m_mode <= 3);
    chk("prog_we",  o_ProgWe,   m_mode == 3);
    chk("prog_addr",o_ProgAddr, m_cnt);
    chk("prog_data",o_ProgData, m_hi * 256 + m_lo);
    chk("cycles",   o_Cycles,   m_cycles);
    chk("done",     o_Done,     m_mode == 6);
    chk("error",    o_Error,    m_err);
    if (o_CpuEn) en_pulses++;
    if (o_ProgWe) begin
      wq_addr.push_back(int'(o_ProgAddr));
      wq_data.push_back(int'(o_ProgData));
    end

    err_n = 0;
    if (exp_en) m_cycles = (m_cycles >= 65535) ? 65535 : m_cycles + 1;
    case (m_mode)
      0: if (v) begin
           if (d == 8'h4C) begin m_mode = 1; m_cnt = 0; m_loaded = 0; end
           else if ((d == 8'h52 || d == 8'h53) && m_loaded) begin
             m_mode = (d == 8'h52) ? 5 : 4; m_cycles = 0;
           end else err_n = 1;
         end
      1: if (v) begin m_lo = d; m_mode = 2; end
      2: if (v) begin m_hi = d; m_mode = 3; end
      3: begin
           if (v) err_n = 1;
           if ((m_hi * 256 + m_lo) / (1 << (DW - OPC_W)) == HALT) begin
             m_loaded = 1; m_mode = 0;
           end else if (m_cnt == DEPTH - 1) begin
             m_loaded = 1; m_mode = 0; err_n = 1;
           end else m_mode = 1;
           m_cnt = (m_cnt + 1) % DEPTH;
         end
      4: if (h) m_mode = 6;
         else if (v) begin
           if (d == 8'h52) m_mode = 5;
           else if (d != 8'h53) err_n = 1;
         end
      5: if (h) m_mode = 6;
      6: if (v) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_err = err_n;
  endtask

  // Asynchronous reset between edges; outputs must snap to reset values.
  task automatic do_reset();
    @(negedge clk);
    i_RxValid = 0; i_RxData = 0; i_Halt = 0;
    #2 i_reset = 1;
    #1;
    chk("rst_state",  o_State,    0);
    chk("rst_cpurst", o_CpuRst,   1);
    chk("rst_cpuen",  o_CpuEn,    0);
    chk("rst_we",     o_ProgWe,   0);
    chk("rst_addr",   o_ProgAddr, 0);
    chk("rst_data",   o_ProgData, 0);
    chk("rst_cycles", o_Cycles,   0);
    chk("rst_done",   o_Done,     0);
    chk("rst_error",  o_Error,    0);
    model_reset();
    @(negedge clk);
    i_reset = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // 'R' straight after reset is rejected; 0x41 in IDLE is an error.
    cyc(1, 8'h52, 0);
    cyc(0, 8'h00, 0);
    chk("lit_r_rejected_err", o_Error, 1);
    chk("lit_r_rejected_st",  o_State, 0);
    cyc(1, 8'h41, 0);
    cyc(0, 8'h00, 0);
    chk("lit_bad_byte_err", o_Error, 1);

    // Byte during WRITE is dropped and flagged.
    cyc(1, 8'h4C, 0); cyc(1, 8'h01, 0); cyc(1, 8'h08, 0);
    cyc(1, 8'h99, 0);
    cyc(0, 8'h00, 0);
    chk("lit_write_drop_err", o_Error, 1);
    chk("lit_write_drop_st",  o_State, 1);
    cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(0, 8'h00, 0);

    // Reference load: two words, halt word last.
    wq_addr.delete(); wq_data.delete();
    cyc(1, 8'h4C, 0);
    cyc(1, 8'h05, 0); cyc(1, 8'h08, 0); cyc(0, 8'h00, 0);
    cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("lit_load_nwr",  wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk("lit_load_a0", wq_addr[0], 0);
      chk("lit_load_d0", wq_data[0], 16'h0805);
      chk("lit_load_a1", wq_addr[1], 1);
      chk("lit_load_d1", wq_data[1], 16'h0000);
    end
    chk("lit_load_err", o_Error, 0);
    chk("lit_load_st",  o_State, 0);

    // Run: three enabled cycles then halt.
    en_pulses = 0;
    cyc(1, 8'h52, 0);
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    chk("lit_run_pulses", en_pulses, 3);
    chk("lit_run_cycles", o_Cycles, 3);
    chk("lit_run_done",   o_Done, 1);
    chk("lit_run_state",  o_State, 6);

    // Leave DONE, then step twice and halt.
    cyc(1, 8'h00, 0);
    en_pulses = 0;
    cyc(1, 8'h53, 0);
    cyc(1, 8'h53, 0); cyc(0, 8'h00, 0); cyc(1, 8'h53, 0);
    cyc(1, 8'h53, 1);
    cyc(0, 8'h00, 0);
    chk("lit_step_pulses", en_pulses, 2);
    chk("lit_step_cycles", o_Cycles, 2);
    chk("lit_step_done",   o_Done, 1);
    cyc(1, 8'h00, 0);

    // Reset mid-load, then 'R' must be rejected.
    cyc(1, 8'h4C, 0); cyc(1, 8'h12, 0);
    do_reset();
    cyc(1, 8'h52, 0);
    cyc(0, 8'h00, 0);
    chk("lit_midload_rej", o_Error, 1);

    // Reset mid-run, then 'R' must be rejected.
    cyc(1, 8'h4C, 0); cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(0, 8'h00, 0);
    cyc(1, 8'h52, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    do_reset();
    cyc(1, 8'h52, 0);
    cyc(0, 8'h00, 0);
    chk("lit_midrun_rej", o_Error, 1);
    chk("lit_midrun_st",  o_State, 0);

    // Fill the whole memory with non-halt words.
    wq_addr.delete(); wq_data.delete();
    cyc(1, 8'h4C, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, i[7:0], 0);
      cyc(1, 8'h08, 0);
      cyc(0, 8'h00, 0);
    end
    cyc(0, 8'h00, 0);
    chk("lit_wrap_err",  o_Error, 1);
    chk("lit_wrap_st",   o_State, 0);
    chk("lit_wrap_nwr",  wq_addr.size(), DEPTH);
    if (wq_addr.size() > 0) chk("lit_wrap_last", wq_addr[wq_addr.size()-1], 32'h7FF);
    chk("lit_wrap_addr", o_ProgAddr, 0);
    cyc(1, 8'h52, 0);
    cyc(0, 8'h00, 0);
    chk("lit_wrap_run", o_State, 5);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
